// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for ADD, LW, SW and BEQ,
// with a memory-ready stall, a hung-access timeout and an illegal-opcode trap.
module multicycle_control_unit #(
  parameter int                 OPC_W       = 6,
  parameter int                 ALUC_W      = 4,
  parameter logic [OPC_W-1:0]   OP_ADD      = 6'b000001,
  parameter logic [OPC_W-1:0]   OP_SW       = 6'b000010,
  parameter logic [OPC_W-1:0]   OP_LW       = 6'b000100,
  parameter logic [OPC_W-1:0]   OP_BEQ      = 6'b001000,
  parameter logic [ALUC_W-1:0]  ALU_ADD     = 4'b0101,
  parameter logic [ALUC_W-1:0]  ALU_SUB     = 4'b0110,
  parameter int                 MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              PCSrc,
  output logic              IorD,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUcontrol,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemToReg,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [3:0]        state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [1:0]         halt_code;
  logic               timed_out;

  assign timed_out  = (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      wait_cnt_q   <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_cnt_d   = '0;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    halt_code    = 2'b01;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUcontrol   = '0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemToReg     = 1'b0;

    // wait_cnt defaults to 0, so it is cleared on every state change and only
    // advances while a memory state keeps waiting; mem_ready beats the timeout.
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUcontrol = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d   = S_HALT;
          halt_code = 2'b10;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUcontrol = ALU_ADD;
        op_d       = opcode;
        if (opcode == OP_ADD)                         state_d = S_EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_ADDR;
        else if (opcode == OP_BEQ)                    state_d = S_BRANCH;
        else                                          state_d = S_HALT;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = ALU_ADD;
        state_d    = S_WB_R;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUcontrol = ALU_ADD;
        state_d    = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        IorD     = 1'b1;
        MemRead  = (state_q == S_MEM_RD);
        MemWrite = (state_q == S_MEM_WR);
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timed_out) begin
          state_d   = S_HALT;
          halt_code = 2'b10;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = ALU_SUB;
        PCWrite    = zero;
        PCSrc      = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (state_d == S_HALT && state_q != S_HALT) begin
      fault_d      = 1'b1;
      fault_code_d = halt_code;
    end

    // Reset aborts instantly: no strobe may leak while rst is held.
    if (rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-level stimulus with a scoreboard queue checked by a negedge monitor.
module tb_multicycle_control_unit;

  localparam int TMO = 15;
  localparam logic [5:0] ADD = 6'b000001, SW = 6'b000010, LW = 6'b000100, BEQ = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IRWrite, PCWrite, PCSrc, IorD, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUcontrol;
  logic       MemRead, MemWrite, MemToReg, fault;
  logic [1:0] fault_code;
  logic [3:0] state;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUcontrol(ALUcontrol),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .fault(fault),
    .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [22:0] exp_q[$];
  logic [22:0] exp_st_q[$];
  bit          m_fault = 1'b0;
  logic [1:0]  m_code = 2'b00;

  // Expected output word for one cycle, from the per-state output table.
  function automatic logic [22:0] expv(int st, bit rdy, bit z, bit r, bit flt, logic [1:0] code);
    bit irw = 0, pcw = 0, pcsrc = 0, iord = 0, rdst = 0, rw = 0, srca = 0, mrd = 0, mwr = 0, m2r = 0;
    logic [1:0] srcb = 2'b00;
    logic [3:0] aluc = 4'b0000;
    case (st)
      0: begin mrd = 1; srcb = 2'b01; aluc = 4'b0101; irw = rdy; pcw = rdy; end
      1: begin srcb = 2'b11; aluc = 4'b0101; end
      2: begin srca = 1; aluc = 4'b0101; end
      3: begin rdst = 1; rw = 1; end
      4: begin srca = 1; srcb = 2'b10; aluc = 4'b0101; end
      5: begin mrd = 1; iord = 1; end
      6: begin mwr = 1; iord = 1; end
      7: begin rw = 1; m2r = 1; end
      8: begin srca = 1; aluc = 4'b0110; pcw = z; pcsrc = 1; end
      default: ;
    endcase
    if (r) begin irw = 0; pcw = 0; rw = 0; mrd = 0; mwr = 0; end
    return {4'(st), irw, pcw, pcsrc, iord, rdst, rw, srca, srcb, aluc, mrd, mwr, m2r, flt, code};
  endfunction

  task automatic cyc(int st, logic [5:0] opc, bit rdy, bit r, int zs = -1);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = opc;
    mem_ready = rdy;
    zero      = (zs < 0) ? 1'($urandom) : 1'(zs);
    exp_q.push_back(expv(st, rdy, zero, r, m_fault, m_code));
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic halt_and_reset(int n);
    repeat (n) cyc(9, rnd_op(), 1'($urandom), 0);
    m_fault = 0;
    m_code  = 2'b00;
    repeat (2) cyc(0, rnd_op(), 1'($urandom), 1);
  endtask

  // A memory wait of m not-ready cycles; more than TMO of them is a hang.
  task automatic mem_wait(int st, int m, output bit to);
    if (m > TMO) begin
      repeat (TMO + 1) cyc(st, rnd_op(), 0, 0);
      m_fault = 1;
      m_code  = 2'b10;
      to      = 1;
    end else begin
      repeat (m) cyc(st, rnd_op(), 0, 0);
      cyc(st, rnd_op(), 1, 0);
      to = 0;
    end
  endtask

  task automatic run_instr(logic [5:0] op, int zs, int f, int m, int hold = 3);
    bit to;
    mem_wait(0, f, to);
    if (to) begin halt_and_reset(hold); return; end
    cyc(1, op, 1'($urandom), 0);
    case (op)
      ADD: begin cyc(2, rnd_op(), 1'($urandom), 0); cyc(3, rnd_op(), 1'($urandom), 0); end
      LW: begin
        cyc(4, rnd_op(), 1'($urandom), 0);
        mem_wait(5, m, to);
        if (to) halt_and_reset(hold);
        else cyc(7, rnd_op(), 1'($urandom), 0);
      end
      SW: begin
        cyc(4, rnd_op(), 1'($urandom), 0);
        mem_wait(6, m, to);
        if (to) halt_and_reset(hold);
      end
      BEQ: cyc(8, rnd_op(), 1'($urandom), 0, zs);
      default: begin
        m_fault = 1;
        m_code  = 2'b01;
        halt_and_reset(hold);
      end
    endcase
  endtask

  initial begin : monitor
    logic [22:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {state, IRWrite, PCWrite, PCSrc, IorD, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUcontrol, MemRead, MemWrite, MemToReg, fault, fault_code};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs exp_state=%0d got=%h exp=%h at %0t", e[22:19], got, e, $time);
        end
      end
    end
  end

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin : stim
    logic [5:0] op;
    int         k;
    repeat (3) cyc(0, rnd_op(), 1'($urandom), 1);

    run_instr(ADD, -1, 0, 0);
    run_instr(LW, -1, 0, 3);
    run_instr(BEQ, 1, 1, 0);
    run_instr(BEQ, 0, 0, 0);
    run_instr(6'b111111, -1, 0, 0, 20);
    run_instr(SW, -1, 0, TMO + 1);
    run_instr(SW, -1, 0, TMO);
    run_instr(LW, -1, 2, TMO + 1);
    run_instr(ADD, -1, TMO + 1, 0);
    run_instr(ADD, -1, TMO, 0);

    // Asynchronous reset landing mid-cycle while a store is waiting.
    cyc(0, rnd_op(), 1, 0);
    cyc(1, SW, 1, 0);
    cyc(4, rnd_op(), 1, 0);
    cyc(6, rnd_op(), 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_memwrite", {7'd0, MemWrite}, 8'd0);
    check("async_rst_state", {4'd0, state}, 8'd0);
    check("async_rst_fault", {5'd0, fault, fault_code}, 8'd0);
    cyc(0, rnd_op(), 1'($urandom), 1);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 19);
      if (k < 5)       op = ADD;
      else if (k < 10) op = LW;
      else if (k < 14) op = SW;
      else if (k < 18) op = BEQ;
      else             op = rnd_op();
      run_instr(op, -1,
                ($urandom_range(0, 29) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, 3),
                ($urandom_range(0, 14) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
